// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings, address-generator state type and burst geometry helpers.
// Pure declarations: no latency, no flow control.
package ahb_params_pkg;

   typedef enum logic [1:0] {IDLE, NSEQ, SEQ, BUSY} ahb_agen_state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HB_SINGLE = 3'd0;
   localparam logic [2:0] HB_INCR   = 3'd1;
   localparam logic [2:0] HB_WRAP4  = 3'd2;
   localparam logic [2:0] HB_INCR4  = 3'd3;
   localparam logic [2:0] HB_WRAP8  = 3'd4;
   localparam logic [2:0] HB_INCR8  = 3'd5;
   localparam logic [2:0] HB_WRAP16 = 3'd6;
   localparam logic [2:0] HB_INCR16 = 3'd7;

   localparam int KB_BOUNDARY = 1024;
   localparam int KB_BITS     = $clog2(KB_BOUNDARY);
   localparam int BEATS_W     = 16;
   localparam int MASK_W      = 64;

   // len is only meaningful for undefined INCR; zero means a single beat
   function automatic logic [BEATS_W-1:0] burst_beats(input logic [2:0] hburst,
                                                      input logic [BEATS_W-1:0] len);
      case (hburst)
         HB_INCR:            burst_beats = (len == '0) ? BEATS_W'(1) : len;
         HB_WRAP4, HB_INCR4:   burst_beats = BEATS_W'(4);
         HB_WRAP8, HB_INCR8:   burst_beats = BEATS_W'(8);
         HB_WRAP16, HB_INCR16: burst_beats = BEATS_W'(16);
         default:            burst_beats = BEATS_W'(1);
      endcase
   endfunction

   function automatic logic [MASK_W-1:0] wrap_mask(input logic [BEATS_W-1:0] beats,
                                                   input logic [2:0] hsize);
      wrap_mask = (MASK_W'(beats) << hsize) - MASK_W'(1);
   endfunction

endpackage

// File: rtl/ahb_addr_incr.sv
// Next beat address (INCR or WRAP) and 1KB-crossing test for a burst span.
// Purely combinational; no flow control.
module ahb_addr_incr
   import ahb_params_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [2:0]            size_i,
   input  logic [BEATS_W-1:0]    beats_i,
   input  logic                  wrap_i,
   output logic [ADDR_WIDTH-1:0] next_addr_o,
   output logic                  next_kb_o,
   output logic                  kb_cross_o
);

   logic [ADDR_WIDTH-1:0] beat_bytes;
   logic [ADDR_WIDTH-1:0] inc_addr;
   logic [ADDR_WIDTH-1:0] wmask;
   logic [ADDR_WIDTH-1:0] span_end;

   always_comb begin
      beat_bytes  = ADDR_WIDTH'(1) << size_i;
      inc_addr    = addr_i + beat_bytes;
      wmask       = ADDR_WIDTH'(wrap_mask(beats_i, size_i));
      next_addr_o = wrap_i ? ((addr_i & ~wmask) | (inc_addr & wmask)) : inc_addr;
      next_kb_o   = (next_addr_o[KB_BITS-1:0] == '0);
      // last byte of the span, modulo 2^ADDR_WIDTH so a top-of-memory wrap also counts
      span_end    = addr_i + (ADDR_WIDTH'(beats_i) << size_i) - ADDR_WIDTH'(1);
      kb_cross_o  = (span_end[ADDR_WIDTH-1:KB_BITS] != addr_i[ADDR_WIDTH-1:KB_BITS]);
   end

endmodule

// File: rtl/ahb_burst_addr_gen.sv
// AHB master address-phase sequencer: command accepted in cycle N issues NONSEQ in N+1, one beat per HREADY.
// Holds all address-phase outputs while HREADY=0; cmd_ready only in IDLE or on last-beat acceptance. Option: AHB_BUSY_INSERT_EN.
module ahb_burst_addr_gen
   import ahb_params_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [2:0]            cmd_burst,
   input  logic [2:0]            cmd_size,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  cmd_write,
   input  logic                  HREADY,
   output logic [1:0]            HTRANS,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [2:0]            HBURST,
   output logic [2:0]            HSIZE,
   output logic                  HWRITE,
   output logic                  beat_acc,
   output logic                  burst_done,
`ifdef AHB_BUSY_INSERT_EN
   input  logic                  busy_req,
`endif
   output logic                  cmd_err
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

   ahb_agen_state_t       state_q, state_d;
   logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic [2:0]            hburst_q, hburst_d;
   logic [2:0]            hsize_q, hsize_d;
   logic                  hwrite_q, hwrite_d;
   logic [BEATS_W-1:0]    beats_left_q, beats_left_d;
   logic                  cmd_err_q, cmd_err_d;

   logic [ADDR_WIDTH-1:0] cmd_addr_al;
   logic [BEATS_W-1:0]    cmd_beats;
   logic                  cmd_fixed_incr;
   logic                  cmd_reject;
   logic                  last_beat;
   logic                  load;

   logic [ADDR_WIDTH-1:0] inc_addr;
   logic [2:0]            inc_size;
   logic [BEATS_W-1:0]    inc_beats;
   logic                  inc_wrap;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  next_kb;
   logic                  kb_cross;

   assign cmd_addr_al    = cmd_addr & ~((ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1));
   assign cmd_beats      = burst_beats(cmd_burst, BEATS_W'(cmd_len));
   assign cmd_fixed_incr = cmd_burst[0] && (cmd_burst != HB_INCR);
   assign cmd_reject     = (cmd_size > MAX_SIZE) || (cmd_fixed_incr && kb_cross);

   assign last_beat  = (beats_left_q == BEATS_W'(1));
   assign beat_acc   = ((state_q == NSEQ) || (state_q == SEQ)) && HREADY;
   assign burst_done = beat_acc && last_beat;
   assign cmd_ready  = (state_q == IDLE) || burst_done;

   // A command is only examined when cmd_ready is high, which never coincides with
   // needing the next beat address, so one incrementer serves both.
   always_comb begin
      if (cmd_ready) begin
         inc_addr  = cmd_addr_al;
         inc_size  = cmd_size;
         inc_beats = cmd_beats;
         inc_wrap  = 1'b0;
      end else begin
         inc_addr  = haddr_q;
         inc_size  = hsize_q;
         inc_beats = burst_beats(hburst_q, BEATS_W'(1));
         inc_wrap  = !hburst_q[0] && (hburst_q != HB_SINGLE);
      end
   end

   ahb_addr_incr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_incr (
      .addr_i      (inc_addr),
      .size_i      (inc_size),
      .beats_i     (inc_beats),
      .wrap_i      (inc_wrap),
      .next_addr_o (next_addr),
      .next_kb_o   (next_kb),
      .kb_cross_o  (kb_cross)
   );

   always_comb begin
      state_d      = state_q;
      haddr_d      = haddr_q;
      hburst_d     = hburst_q;
      hsize_d      = hsize_q;
      hwrite_d     = hwrite_q;
      beats_left_d = beats_left_q;
      cmd_err_d    = 1'b0;
      load         = 1'b0;

      case (state_q)
         IDLE: load = cmd_valid;
         NSEQ, SEQ: begin
            if (HREADY) begin
               if (last_beat) begin
                  state_d = IDLE;
                  load    = cmd_valid;
               end else begin
                  haddr_d      = next_addr;
                  beats_left_d = beats_left_q - BEATS_W'(1);
                  // undefined-length INCR restarts with NONSEQ on each 1KB boundary
                  if ((hburst_q == HB_INCR) && next_kb) begin
                     state_d = NSEQ;
                  end else begin
`ifdef AHB_BUSY_INSERT_EN
                     state_d = busy_req ? BUSY : SEQ;
`else
                     state_d = SEQ;
`endif
                  end
               end
            end
         end
         BUSY: begin
`ifdef AHB_BUSY_INSERT_EN
            if (HREADY && !busy_req) state_d = SEQ;
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         if (cmd_reject) begin
            cmd_err_d = 1'b1;
         end else begin
            state_d      = NSEQ;
            haddr_d      = cmd_addr_al;
            hburst_d     = cmd_burst;
            hsize_d      = cmd_size;
            hwrite_d     = cmd_write;
            beats_left_d = cmd_beats;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= IDLE;
         haddr_q      <= '0;
         hburst_q     <= HB_SINGLE;
         hsize_q      <= 3'd0;
         hwrite_q     <= 1'b0;
         beats_left_q <= '0;
         cmd_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         haddr_q      <= haddr_d;
         hburst_q     <= hburst_d;
         hsize_q      <= hsize_d;
         hwrite_q     <= hwrite_d;
         beats_left_q <= beats_left_d;
         cmd_err_q    <= cmd_err_d;
      end
   end

   always_comb begin
      case (state_q)
         NSEQ:    HTRANS = HTRANS_NONSEQ;
         SEQ:     HTRANS = HTRANS_SEQ;
         BUSY:    HTRANS = HTRANS_BUSY;
         default: HTRANS = HTRANS_IDLE;
      endcase
   end

   assign HADDR   = haddr_q;
   assign HBURST  = hburst_q;
   assign HSIZE   = hsize_q;
   assign HWRITE  = hwrite_q;
   assign cmd_err = cmd_err_q;

endmodule
